// File: rtl/kv_map_arbiter_if.sv
// ---------------------------------------------------------------------------
// kv_map_arbiter_if
// Bundles the requester-side and kv-map-side signals of kv_map_arbiter.
//   Requester r (r0/r1) : insert/find strobes with key/value in, busy and
//                         find result (stb/match/value) out.
//   kv-map side         : insert/find strobes with key/value out,
//                         kv_map_busy and find result in.
//   overflow_err        : sticky slot-overflow flag out of the arbiter.
// Modports: slave = arbiter view, master = environment view.
// ---------------------------------------------------------------------------
interface kv_map_arbiter_if #(
    parameter int KEY_W = 16,
    parameter int VAL_W = 112
);
    logic             r0_insert_stb, r1_insert_stb;
    logic [KEY_W-1:0] r0_insert_key, r1_insert_key;
    logic [VAL_W-1:0] r0_insert_value, r1_insert_value;
    logic             r0_find_stb, r1_find_stb;
    logic [KEY_W-1:0] r0_find_key, r1_find_key;
    logic             r0_busy, r1_busy;
    logic             r0_find_res_stb, r1_find_res_stb;
    logic             r0_find_res_match, r1_find_res_match;
    logic [VAL_W-1:0] r0_find_res_value, r1_find_res_value;
    logic             insert_key_stb;
    logic [KEY_W-1:0] insert_key;
    logic [VAL_W-1:0] insert_value;
    logic             find_key_stb;
    logic [KEY_W-1:0] find_key;
    logic             kv_map_busy;
    logic             find_res_stb;
    logic             find_res_match;
    logic [VAL_W-1:0] find_res_value;
    logic             overflow_err;

    modport slave (
        input  r0_insert_stb, r0_insert_key, r0_insert_value, r0_find_stb, r0_find_key,
        input  r1_insert_stb, r1_insert_key, r1_insert_value, r1_find_stb, r1_find_key,
        output r0_busy, r0_find_res_stb, r0_find_res_match, r0_find_res_value,
        output r1_busy, r1_find_res_stb, r1_find_res_match, r1_find_res_value,
        output insert_key_stb, insert_key, insert_value, find_key_stb, find_key,
        input  kv_map_busy, find_res_stb, find_res_match, find_res_value,
        output overflow_err
    );

    modport master (
        output r0_insert_stb, r0_insert_key, r0_insert_value, r0_find_stb, r0_find_key,
        output r1_insert_stb, r1_insert_key, r1_insert_value, r1_find_stb, r1_find_key,
        input  r0_busy, r0_find_res_stb, r0_find_res_match, r0_find_res_value,
        input  r1_busy, r1_find_res_stb, r1_find_res_match, r1_find_res_value,
        input  insert_key_stb, insert_key, insert_value, find_key_stb, find_key,
        output kv_map_busy, find_res_stb, find_res_match, find_res_value,
        input  overflow_err
    );
endinterface

// File: rtl/kv_map_arbiter.sv
// ---------------------------------------------------------------------------
// kv_map_arbiter
// Two-requester front end for a single kv-map. Each requester owns one
// pending insert slot and one pending find slot; a round-robin FSM issues
// one kv-map operation at a time (insert before find within a requester)
// and routes find results back to the requester that issued the find.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : kv_map_arbiter_if.slave (requester, kv-map and overflow_err)
// Optional feature: define KV_MAP_ARBITER_TIMEOUT_EN to bound WAIT_RES to
// TIMEOUT_CYC cycles; a timed-out find returns match=0, value=0.
// ---------------------------------------------------------------------------
module kv_map_arbiter #(
    parameter int KEY_W       = 16,
    parameter int VAL_W       = 112,
    parameter int TIMEOUT_CYC = 256
) (
    input logic             clk,
    input logic             rst_n,
    kv_map_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE_INS, ISSUE_FIND, WAIT_RES} state_t;

    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("kv_map_arbiter: TIMEOUT_CYC out of range 2..65535");
    end

    // requester inputs gathered into index-by-requester vectors
    logic [1:0]            w_ins_stb, w_find_stb;
    logic [1:0][KEY_W-1:0] w_ins_key, w_find_key;
    logic [1:0][VAL_W-1:0] w_ins_val;
    assign w_ins_stb  = {bus.r1_insert_stb,   bus.r0_insert_stb};
    assign w_ins_key  = {bus.r1_insert_key,   bus.r0_insert_key};
    assign w_ins_val  = {bus.r1_insert_value, bus.r0_insert_value};
    assign w_find_stb = {bus.r1_find_stb,     bus.r0_find_stb};
    assign w_find_key = {bus.r1_find_key,     bus.r0_find_key};

    state_t                r_state;
    logic                  r_ptr, r_owner;
    logic [1:0]            r_ins_occ, r_find_occ;
    logic [1:0][KEY_W-1:0] r_ins_key, r_find_key;
    logic [1:0][VAL_W-1:0] r_ins_val;
    logic                  r_ins_stb_o, r_find_stb_o;
    logic [KEY_W-1:0]      r_ins_key_o, r_find_key_o;
    logic [VAL_W-1:0]      r_ins_val_o;
    logic [1:0]            r_res_stb, r_res_match;
    logic [1:0][VAL_W-1:0] r_res_val;
    logic                  r_ovf;

    logic w_tmo;
`ifdef KV_MAP_ARBITER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] r_tmo_cnt;
    // counter is 0 in the first WAIT_RES cycle, so the result lands exactly
    // TIMEOUT_CYC cycles after WAIT_RES was entered
    assign w_tmo = (r_state == WAIT_RES) && (r_tmo_cnt == TMO_LAST);
`else
    assign w_tmo = 1'b0;
`endif

    logic [1:0] w_pend, w_owner_oh, w_ins_free, w_find_free, w_busy;
    logic       w_res_done, w_gnt, w_gnt_id;
    assign w_pend      = r_ins_occ | r_find_occ;
    assign w_owner_oh  = r_owner ? 2'b10 : 2'b01;
    assign w_res_done  = (r_state == WAIT_RES) && (bus.find_res_stb || w_tmo);
    assign w_ins_free  = (r_state == ISSUE_INS) ? w_owner_oh : 2'b00;
    assign w_find_free = w_res_done ? w_owner_oh : 2'b00;
    assign w_busy      = w_pend | ((r_state != IDLE) ? w_owner_oh : 2'b00);
    assign w_gnt       = (r_state == IDLE) && !bus.kv_map_busy && (|w_pend);
    assign w_gnt_id    = w_pend[r_ptr] ? r_ptr : ~r_ptr;

    // Slots: a strobe is taken when the slot is empty or being freed this
    // very cycle; otherwise it is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ins_occ  <= '0;
            r_find_occ <= '0;
            r_ins_key  <= '0;
            r_ins_val  <= '0;
            r_find_key <= '0;
            r_ovf      <= 1'b0;
        end else begin
            for (int r = 0; r < 2; r++) begin
                if (w_ins_stb[r]) begin
                    if (!r_ins_occ[r] || w_ins_free[r]) begin
                        r_ins_occ[r] <= 1'b1;
                        r_ins_key[r] <= w_ins_key[r];
                        r_ins_val[r] <= w_ins_val[r];
                    end else begin
                        r_ovf <= 1'b1;
                    end
                end else if (w_ins_free[r]) begin
                    r_ins_occ[r] <= 1'b0;
                end
                if (w_find_stb[r]) begin
                    if (!r_find_occ[r] || w_find_free[r]) begin
                        r_find_occ[r] <= 1'b1;
                        r_find_key[r] <= w_find_key[r];
                    end else begin
                        r_ovf <= 1'b1;
                    end
                end else if (w_find_free[r]) begin
                    r_find_occ[r] <= 1'b0;
                end
            end
        end
    end

    // Arbitration FSM with registered kv-side and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ptr        <= 1'b0;
            r_owner      <= 1'b0;
            r_ins_stb_o  <= 1'b0;
            r_ins_key_o  <= '0;
            r_ins_val_o  <= '0;
            r_find_stb_o <= 1'b0;
            r_find_key_o <= '0;
            r_res_stb    <= '0;
            r_res_match  <= '0;
            r_res_val    <= '0;
`ifdef KV_MAP_ARBITER_TIMEOUT_EN
            r_tmo_cnt    <= '0;
`endif
        end else begin
            r_res_stb <= '0;
            case (r_state)
                IDLE: begin
                    if (w_gnt) begin
                        r_owner <= w_gnt_id;
                        r_ptr   <= ~r_ptr;
                        if (r_ins_occ[w_gnt_id]) begin
                            r_ins_stb_o <= 1'b1;
                            r_ins_key_o <= r_ins_key[w_gnt_id];
                            r_ins_val_o <= r_ins_val[w_gnt_id];
                            r_state     <= ISSUE_INS;
                        end else begin
                            r_find_stb_o <= 1'b1;
                            r_find_key_o <= r_find_key[w_gnt_id];
                            r_state      <= ISSUE_FIND;
                        end
                    end
                end
                ISSUE_INS: begin
                    r_ins_stb_o <= 1'b0;
                    r_state     <= IDLE;
                end
                ISSUE_FIND: begin
                    r_find_stb_o <= 1'b0;
                    r_state      <= WAIT_RES;
`ifdef KV_MAP_ARBITER_TIMEOUT_EN
                    r_tmo_cnt    <= '0;
`endif
                end
                WAIT_RES: begin
                    if (bus.find_res_stb) begin
                        r_res_stb[r_owner]   <= 1'b1;
                        r_res_match[r_owner] <= bus.find_res_match;
                        r_res_val[r_owner]   <= bus.find_res_value;
                        r_state              <= IDLE;
                    end
`ifdef KV_MAP_ARBITER_TIMEOUT_EN
                    else if (w_tmo) begin
                        r_res_stb[r_owner]   <= 1'b1;
                        r_res_match[r_owner] <= 1'b0;
                        r_res_val[r_owner]   <= '0;
                        r_state              <= IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.r0_busy           = w_busy[0];
    assign bus.r1_busy           = w_busy[1];
    assign bus.r0_find_res_stb   = r_res_stb[0];
    assign bus.r1_find_res_stb   = r_res_stb[1];
    assign bus.r0_find_res_match = r_res_match[0];
    assign bus.r1_find_res_match = r_res_match[1];
    assign bus.r0_find_res_value = r_res_val[0];
    assign bus.r1_find_res_value = r_res_val[1];
    assign bus.insert_key_stb    = r_ins_stb_o;
    assign bus.insert_key        = r_ins_key_o;
    assign bus.insert_value      = r_ins_val_o;
    assign bus.find_key_stb      = r_find_stb_o;
    assign bus.find_key          = r_find_key_o;
    assign bus.overflow_err      = r_ovf;
endmodule

// File: tb/tb_kv_map_arbiter.sv
// Self-checking bench for kv_map_arbiter: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a transaction model.
module tb_kv_map_arbiter;
    localparam logic [111:0] A5 = {14{8'hA5}};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    kv_map_arbiter_if #(.KEY_W(16), .VAL_W(112)) bus ();
    kv_map_arbiter #(.KEY_W(16), .VAL_W(112), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    // bench-side drivers
    logic [1:0]   t_ins_stb, t_find_stb;
    logic [15:0]  t_ins_key [2];
    logic [15:0]  t_find_key [2];
    logic [111:0] t_ins_val [2];
    logic         t_kbusy, t_res_stb, t_res_match;
    logic [111:0] t_res_val;
    assign bus.r0_insert_stb   = t_ins_stb[0];
    assign bus.r1_insert_stb   = t_ins_stb[1];
    assign bus.r0_insert_key   = t_ins_key[0];
    assign bus.r1_insert_key   = t_ins_key[1];
    assign bus.r0_insert_value = t_ins_val[0];
    assign bus.r1_insert_value = t_ins_val[1];
    assign bus.r0_find_stb     = t_find_stb[0];
    assign bus.r1_find_stb     = t_find_stb[1];
    assign bus.r0_find_key     = t_find_key[0];
    assign bus.r1_find_key     = t_find_key[1];
    assign bus.kv_map_busy     = t_kbusy;
    assign bus.find_res_stb    = t_res_stb;
    assign bus.find_res_match  = t_res_match;
    assign bus.find_res_value  = t_res_val;

    wire [1:0] o_busy = {bus.r1_busy, bus.r0_busy};
    wire [1:0] o_rstb = {bus.r1_find_res_stb, bus.r0_find_res_stb};
    wire [1:0] o_rm   = {bus.r1_find_res_match, bus.r0_find_res_match};
    logic [111:0] o_rv [2];
    assign o_rv[0] = bus.r0_find_res_value;
    assign o_rv[1] = bus.r1_find_res_value;

    int checks, errors;

    task automatic chk1(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask
    task automatic chkk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask
    task automatic chkv(input string nm, input logic [111:0] got, input logic [111:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [111:0] pat(input logic [15:0] k);
        return {7{k}};
    endfunction
    function automatic logic [111:0] rnd_val();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[111:0];
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in;
        t_ins_stb = '0; t_find_stb = '0;
        for (int r = 0; r < 2; r++) begin
            t_ins_key[r] = '0; t_find_key[r] = '0; t_ins_val[r] = '0;
        end
        t_kbusy = 1'b0; t_res_stb = 1'b0; t_res_match = 1'b0; t_res_val = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk1({tag, " ins_stb"}, bus.insert_key_stb, 1'b0);
        chkk({tag, " ins_key"}, bus.insert_key, 16'h0);
        chkv({tag, " ins_val"}, bus.insert_value, '0);
        chk1({tag, " find_stb"}, bus.find_key_stb, 1'b0);
        chkk({tag, " find_key"}, bus.find_key, 16'h0);
        chk1({tag, " ovf"}, bus.overflow_err, 1'b0);
        for (int r = 0; r < 2; r++) begin
            chk1({tag, " busy"}, o_busy[r], 1'b0);
            chk1({tag, " res_stb"}, o_rstb[r], 1'b0);
            chk1({tag, " res_match"}, o_rm[r], 1'b0);
            chkv({tag, " res_val"}, o_rv[r], '0);
        end
    endtask

    // ---------------- transaction model for the random phase -------------
    // m_phase: 0 idle, 1 insert on the bus, 2 find on the bus, 3 awaiting result
    bit           m_ins [2], m_find [2];
    logic [15:0]  m_ik [2], m_fk [2];
    logic [111:0] m_iv [2];
    int           m_phase;
    bit           m_ptr, m_own, m_ovf;
    logic [15:0]  m_lik, m_lfk;
    logic [111:0] m_liv;
    bit           m_rm [2];
    logic [111:0] m_rv [2];
    int           resp_wait;

    task automatic m_reset;
        for (int r = 0; r < 2; r++) begin
            m_ins[r] = 0; m_find[r] = 0; m_ik[r] = '0; m_fk[r] = '0; m_iv[r] = '0;
            m_rm[r] = 0; m_rv[r] = '0;
        end
        m_phase = 0; m_ptr = 0; m_own = 0; m_ovf = 0;
        m_lik = '0; m_lfk = '0; m_liv = '0; resp_wait = 0;
    endtask

    task automatic do_reset;
        clr_in();
        rst_n = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rst_n = 1'b1;
        m_reset();
    endtask

    // One random cycle: t_* still hold last cycle's inputs, model holds last
    // cycle's state, so DUT outputs now follow from the two.
    task automatic rand_cycle;
        bit eg, gi, gf, res, g;
        bit fi [2];
        bit ff [2];
        eg  = (m_phase == 0) && !t_kbusy && (m_ins[0] || m_find[0] || m_ins[1] || m_find[1]);
        g   = (m_ins[m_ptr] || m_find[m_ptr]) ? m_ptr : !m_ptr;
        gi  = eg && m_ins[g];
        gf  = eg && !m_ins[g];
        res = (m_phase == 3) && t_res_stb;
        if (gi) begin m_lik = m_ik[g]; m_liv = m_iv[g]; end
        if (gf) m_lfk = m_fk[g];
        chk1("rnd ins_stb", bus.insert_key_stb, gi);
        chkk("rnd ins_key", bus.insert_key, m_lik);
        chkv("rnd ins_val", bus.insert_value, m_liv);
        chk1("rnd find_stb", bus.find_key_stb, gf);
        chkk("rnd find_key", bus.find_key, m_lfk);
        for (int r = 0; r < 2; r++) begin
            bit rs;
            rs = res && (m_own == r);
            if (rs) begin m_rm[r] = t_res_match; m_rv[r] = t_res_val; end
            chk1("rnd res_stb", o_rstb[r], rs);
            chk1("rnd res_match", o_rm[r], m_rm[r]);
            chkv("rnd res_val", o_rv[r], m_rv[r]);
        end
        for (int r = 0; r < 2; r++) begin
            fi[r] = (m_phase == 1) && (m_own == r);
            ff[r] = res && (m_own == r);
            if (t_ins_stb[r]) begin
                if (!m_ins[r] || fi[r]) begin
                    m_ins[r] = 1; m_ik[r] = t_ins_key[r]; m_iv[r] = t_ins_val[r];
                end else m_ovf = 1;
            end else if (fi[r]) m_ins[r] = 0;
            if (t_find_stb[r]) begin
                if (!m_find[r] || ff[r]) begin
                    m_find[r] = 1; m_fk[r] = t_find_key[r];
                end else m_ovf = 1;
            end else if (ff[r]) m_find[r] = 0;
        end
        if (eg) begin
            m_own = g; m_ptr = !m_ptr; m_phase = gi ? 1 : 2;
        end else if (m_phase == 1) m_phase = 0;
        else if (m_phase == 2) m_phase = 3;
        else if (res) m_phase = 0;
        for (int r = 0; r < 2; r++)
            chk1("rnd busy", o_busy[r], m_ins[r] || m_find[r] || (m_phase != 0 && m_own == r));
        chk1("rnd ovf", bus.overflow_err, m_ovf);
        // kv responder: answer 1..4 cycles into the wait, plus stray strobes
        if (gf) resp_wait = $urandom_range(2, 5);
        t_res_stb = 1'b0; t_res_match = 1'b0;
        if (resp_wait > 0) begin
            resp_wait--;
            if (resp_wait == 0) begin
                t_res_stb = 1'b1; t_res_match = 1'($urandom % 2); t_res_val = rnd_val();
            end
        end else if (m_phase != 3 && ($urandom % 8) == 0) begin
            t_res_stb = 1'b1; t_res_match = 1'b1; t_res_val = rnd_val();
        end
        t_kbusy = (($urandom % 4) == 0);
        for (int r = 0; r < 2; r++) begin
            t_ins_stb[r]  = (($urandom % 4) == 0);
            t_ins_key[r]  = 16'($urandom);
            t_ins_val[r]  = rnd_val();
            t_find_stb[r] = (($urandom % 5) == 0);
            t_find_key[r] = 16'($urandom);
        end
    endtask

    // ---------------- directed vector table -------------------------------
    typedef struct {
        logic r0i; logic [15:0] r0k; logic r1f; logic [15:0] r1k;
        logic kb;  logic kr;         logic km;
        logic ei;  logic [15:0] eik; logic ef;  logic [15:0] efk;
        logic er;  logic erm;        logic eo;
    } vec_t;
    vec_t tbl [12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0;
        clr_in();
        m_reset();
        //            r0i   r0k       r1f   r1k       kb    kr    km    ei    eik       ef    efk       er    erm   eo
        tbl[0]  = '{1'b1, 16'h1234, 1'b1, 16'h5678, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, 16'h5678, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h1234, 1'b0, 16'h5678, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 16'h5678, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 16'h2222, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 16'h5678, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1111, 1'b0, 16'h5678, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1111, 1'b0, 16'h5678, 1'b0, 1'b1, 1'b1};
        tbl[10] = tbl[9];
        tbl[11] = tbl[9];

        do_reset();
        for (int i = 0; i < 12; i++) begin
            chk1("tbl ins_stb", bus.insert_key_stb, tbl[i].ei);
            chkk("tbl ins_key", bus.insert_key, tbl[i].eik);
            chkv("tbl ins_val", bus.insert_value, pat(tbl[i].eik));
            chk1("tbl find_stb", bus.find_key_stb, tbl[i].ef);
            chkk("tbl find_key", bus.find_key, tbl[i].efk);
            chk1("tbl r1_res_stb", o_rstb[1], tbl[i].er);
            chk1("tbl r1_res_match", o_rm[1], tbl[i].erm);
            chkv("tbl r1_res_val", o_rv[1], tbl[i].erm ? A5 : 112'h0);
            chk1("tbl r0_res_stb", o_rstb[0], 1'b0);
            chk1("tbl ovf", bus.overflow_err, tbl[i].eo);
            t_ins_stb[0]  = tbl[i].r0i; t_ins_key[0] = tbl[i].r0k; t_ins_val[0] = pat(tbl[i].r0k);
            t_find_stb[1] = tbl[i].r1f; t_find_key[1] = tbl[i].r1k;
            t_kbusy = tbl[i].kb; t_res_stb = tbl[i].kr; t_res_match = tbl[i].km;
            t_res_val = tbl[i].kr ? A5 : 112'h0;
            step();
        end

        // busy gating: 10 busy cycles hold the pending insert back
        do_reset();
        t_kbusy = 1'b1;
        t_ins_stb[0] = 1'b1; t_ins_key[0] = 16'hBEEF; t_ins_val[0] = pat(16'hBEEF);
        step();
        t_ins_stb[0] = 1'b0;
        for (int k = 1; k < 10; k++) begin
            chk1("gate no ins", bus.insert_key_stb, 1'b0);
            chk1("gate r0 busy", o_busy[0], 1'b1);
            step();
        end
        chk1("gate no ins", bus.insert_key_stb, 1'b0);
        t_kbusy = 1'b0;
        step();
        chk1("gate ins_stb", bus.insert_key_stb, 1'b1);
        chkk("gate ins_key", bus.insert_key, 16'hBEEF);
        chkv("gate ins_val", bus.insert_value, pat(16'hBEEF));
        step();
        chk1("gate ins one cycle", bus.insert_key_stb, 1'b0);

        // find result routing to r1, answer 5 cycles after the find strobe
        do_reset();
        t_find_stb[1] = 1'b1; t_find_key[1] = 16'h0F0F;
        step();
        clr_in();
        step();
        chk1("route find_stb", bus.find_key_stb, 1'b1);
        chkk("route find_key", bus.find_key, 16'h0F0F);
        for (int k = 3; k < 7; k++) begin
            step();
            chk1("route early res", o_rstb[1], 1'b0);
        end
        step();
        t_res_stb = 1'b1; t_res_match = 1'b1; t_res_val = A5;
        step();
        clr_in();
        chk1("route r1 res_stb", o_rstb[1], 1'b1);
        chk1("route r1 match", o_rm[1], 1'b1);
        chkv("route r1 val", o_rv[1], A5);
        chk1("route r0 res_stb", o_rstb[0], 1'b0);
        chk1("route r0 match", o_rm[0], 1'b0);
        chkv("route r0 val", o_rv[0], '0);
        step();
        chk1("route r1 res one cycle", o_rstb[1], 1'b0);
        chk1("route r1 match held", o_rm[1], 1'b1);
        chk1("route r1 busy clear", o_busy[1], 1'b0);

        // unanswered find: timeout when enabled, indefinite wait otherwise
        t_find_stb[1] = 1'b1; t_find_key[1] = 16'h4444;
        step();
        clr_in();
        step();
        chk1("tmo find_stb", bus.find_key_stb, 1'b1);
        step();
`ifdef KV_MAP_ARBITER_TIMEOUT_EN
        for (int k = 0; k < 15; k++) begin
            chk1("tmo early res", o_rstb[1], 1'b0);
            step();
        end
        chk1("tmo early res", o_rstb[1], 1'b0);
        step();
        chk1("tmo res_stb", o_rstb[1], 1'b1);
        chk1("tmo match", o_rm[1], 1'b0);
        chkv("tmo val", o_rv[1], '0);
        t_ins_stb[0] = 1'b1; t_ins_key[0] = 16'h7777; t_ins_val[0] = pat(16'h7777);
        step();
        clr_in();
        chk1("tmo r1 busy clear", o_busy[1], 1'b0);
        step();
        chk1("tmo idle ins_stb", bus.insert_key_stb, 1'b1);
        chkk("tmo idle ins_key", bus.insert_key, 16'h7777);
`else
        for (int k = 0; k < 40; k++) step();
        chk1("wait no res", o_rstb[1], 1'b0);
        chk1("wait match held", o_rm[1], 1'b1);
        chk1("wait r1 busy", o_busy[1], 1'b1);
`endif

        // reset pulse in the middle of WAIT_RES
        do_reset();
        t_find_stb[0] = 1'b1; t_find_key[0] = 16'h3333;
        step();
        clr_in();
        step();
        chk1("rstw find_stb", bus.find_key_stb, 1'b1);
        step();
        step();
        chk1("rstw r0 busy", o_busy[0], 1'b1);
        rst_n = 1'b0;
        #2;
        check_all_zero("rstw");
        step();
        rst_n = 1'b1;
        t_res_stb = 1'b1; t_res_match = 1'b1; t_res_val = A5;
        step();
        clr_in();
        chk1("rstw late res", o_rstb[0], 1'b0);
        chk1("rstw late match", o_rm[0], 1'b0);
        chk1("rstw busy", o_busy[0], 1'b0);
        step();
        chk1("rstw late res2", o_rstb[0], 1'b0);
        chk1("rstw find idle", bus.find_key_stb, 1'b0);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rand_cycle();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
